alu: RTL and testbench

Registered 32-bit integer ALU for the KGP-miniRISC datapath, in the execute stage. It applies one of eleven operations to two 32-bit operands: arithmetic, logic, and immediate or variable shifts. It produces a 32-bit result plus negative, zero and carry flags, which feed the branch logic. Results are computed combinationally and captured in output registers, so every result is valid one clock after its operands.

---
 rtl/alu_pkg.sv | 16 +
 rtl/alu_shifter.sv | 30 +++
 rtl/alu.sv | 83 ++++++++
 tb/tb_alu.sv | 91 +++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcode encodings and datapath width for the KGP-miniRISC ALU and control unit.
package alu_pkg;
  localparam int WIDTH = 32;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_XOR  = 4'd3;
  localparam logic [3:0] ALU_SLL  = 4'd4;
  localparam logic [3:0] ALU_SRL  = 4'd5;
  localparam logic [3:0] ALU_SRA  = 4'd6;
  localparam logic [3:0] ALU_SLLV = 4'd7;
  localparam logic [3:0] ALU_SRLV = 4'd8;
  localparam logic [3:0] ALU_SRAV = 4'd9;
  localparam logic [3:0] ALU_COMP = 4'd10;
endpackage

// File: rtl/alu_shifter.sv
// Combinational 32-bit barrel shifter that also reports the last bit shifted out.
module alu_shifter
  import alu_pkg::*;
(
  input  logic [WIDTH-1:0] data,
  input  logic [4:0]       amount,
  input  logic             left,
  input  logic             arith,
  output logic [WIDTH-1:0] result,
  output logic             shift_out
);
  logic [WIDTH:0] ext_l;
  logic [WIDTH:0] ext_r;

  // A guard bit on the far side catches the last bit out; amount 0 leaves it at 0.
  always_comb begin
    ext_l = {1'b0, data} << amount;
    if (arith)
      ext_r = $unsigned($signed({data, 1'b0}) >>> amount);
    else
      ext_r = {data, 1'b0} >> amount;
    if (left) begin
      result    = ext_l[WIDTH-1:0];
      shift_out = ext_l[WIDTH];
    end else begin
      result    = ext_r[WIDTH:1];
      shift_out = ext_r[0];
    end
  end
endmodule

// File: rtl/alu.sv
// Registered execute-stage ALU: arithmetic, logic and shift ops with N/Z/C flags, one-cycle latency.
module alu
  import alu_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] input1,
  input  logic [WIDTH-1:0] input2,
  input  logic [4:0]       shamt,
  input  logic [3:0]       alu_control_signal,
  output logic [WIDTH-1:0] out_from_ALU,
  output logic             negative,
  output logic             zero,
  output logic             carry
);
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] sh_result;
  logic             sh_out;
  logic [4:0]       sh_amt;
  logic             sh_left;
  logic             sh_arith;
  logic [WIDTH-1:0] res;
  logic             cy;

  // SUB shares the adder: B is inverted and the +1 comes in as carry-in.
  always_comb begin
    if (alu_control_signal == ALU_SUB)
      sum = {1'b0, input1} + {1'b0, ~input2} + {{WIDTH{1'b0}}, 1'b1};
    else
      sum = {1'b0, input1} + {1'b0, input2};
  end

  always_comb begin
    sh_amt   = (alu_control_signal >= ALU_SLLV) ? input2[4:0] : shamt;
    sh_left  = (alu_control_signal == ALU_SLL) || (alu_control_signal == ALU_SLLV);
    sh_arith = (alu_control_signal == ALU_SRA) || (alu_control_signal == ALU_SRAV);
  end

  alu_shifter u_shifter (
    .data      (input1),
    .amount    (sh_amt),
    .left      (sh_left),
    .arith     (sh_arith),
    .result    (sh_result),
    .shift_out (sh_out)
  );

  always_comb begin
    res = '0;
    cy  = 1'b0;
    case (alu_control_signal)
      ALU_ADD, ALU_SUB: begin
        res = sum[WIDTH-1:0];
        cy  = sum[WIDTH];
      end
      ALU_AND:  res = input1 & input2;
      ALU_XOR:  res = input1 ^ input2;
      ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLLV, ALU_SRLV, ALU_SRAV: begin
        res = sh_result;
        cy  = sh_out;
      end
      ALU_COMP: res = ~input2 + {{(WIDTH-1){1'b0}}, 1'b1};
      default: begin
        res = '0;
        cy  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_from_ALU <= '0;
      negative     <= 1'b0;
      zero         <= 1'b1;
      carry        <= 1'b0;
    end else begin
      out_from_ALU <= res;
      negative     <= res[WIDTH-1];
      zero         <= (res == '0);
      carry        <= cy;
    end
  end
endmodule

// File: tb/tb_alu.sv
// Directed-vector bench for the registered ALU; every expected value is hand-computed.
module tb_alu;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] input1, input2;
  logic [4:0]  shamt;
  logic [3:0]  alu_control_signal;
  logic [31:0] out_from_ALU;
  logic        negative, zero, carry;

  int vectors = 0;
  int miscompares = 0;

  alu dut (
    .clk                (clk),
    .rst                (rst),
    .input1             (input1),
    .input2             (input2),
    .shamt              (shamt),
    .alu_control_signal (alu_control_signal),
    .out_from_ALU       (out_from_ALU),
    .negative           (negative),
    .zero               (zero),
    .carry              (carry)
  );

  always #5 clk = ~clk;

  // Drive one op at the falling edge, let one rising edge capture it, check just after.
  task automatic step(input string tag, input logic r, input logic [3:0] op,
                      input logic [31:0] a, input logic [31:0] b, input logic [4:0] sh,
                      input logic [31:0] e_out, input logic e_n, input logic e_z, input logic e_c);
    logic [34:0] got, exp;
    @(negedge clk);
    rst = r; alu_control_signal = op; input1 = a; input2 = b; shamt = sh;
    @(posedge clk);
    #1;
    got = {out_from_ALU, negative, zero, carry};
    exp = {e_out, e_n, e_z, e_c};
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: got out=%h n=%b z=%b c=%b, expected out=%h n=%b z=%b c=%b",
             tag, got[34:3], got[2], got[1], got[0], e_out, e_n, e_z, e_c);
    end
  endtask

  initial begin
    rst = 1'b1; input1 = '0; input2 = '0; shamt = '0; alu_control_signal = '0;

    // Reset with arbitrary operands, then the first post-reset result.
    step("reset",      1'b1, 4'd0,  32'h1234_5678, 32'h9ABC_DEF0, 5'd7, 32'h0, 0, 1, 0);
    step("reset_sub",  1'b1, 4'd1,  32'h0000_0000, 32'h0000_0001, 5'd3, 32'h0, 0, 1, 0);
    step("add_32_53",  1'b0, 4'd0,  32'd32, 32'd53, 5'd0, 32'd85, 0, 0, 0);

    step("sub_32_53",  1'b0, 4'd1,  32'd32, 32'd53, 5'd0, 32'hFFFF_FFEB, 1, 0, 0);
    step("sub_53_32",  1'b0, 4'd1,  32'd53, 32'd32, 5'd0, 32'd21, 0, 0, 1);
    step("add_wrap",   1'b0, 4'd0,  32'hFFFF_FFFF, 32'd1, 5'd0, 32'h0, 0, 1, 1);
    step("comp_5",     1'b0, 4'd10, 32'hDEAD_BEEF, 32'd5, 5'd0, 32'hFFFF_FFFB, 1, 0, 0);

    step("and",        1'b0, 4'd2,  32'd30, 32'd312, 5'd0, 32'd24, 0, 0, 0);
    step("xor",        1'b0, 4'd3,  32'd32, 32'd452, 5'd0, 32'd484, 0, 0, 0);

    step("sll_0",      1'b0, 4'd4,  32'd31, 32'hFFFF_FFFF, 5'd0, 32'd31, 0, 0, 0);
    step("srl_1",      1'b0, 4'd5,  32'd302, 32'd0, 5'd1, 32'd151, 0, 0, 0);
    step("sra_1",      1'b0, 4'd6,  32'h8000_0001, 32'd0, 5'd1, 32'hC000_0000, 1, 0, 1);
    step("sll_out",    1'b0, 4'd4,  32'h8000_0000, 32'd0, 5'd1, 32'h0, 0, 1, 1);
    step("sll_31",     1'b0, 4'd4,  32'h0000_0003, 32'd0, 5'd31, 32'h8000_0000, 1, 0, 1);
    step("srl_31",     1'b0, 4'd5,  32'h8000_0000, 32'd0, 5'd31, 32'h0000_0001, 0, 0, 0);

    step("srlv_4",     1'b0, 4'd8,  32'h0000_00F0, 32'hFFFF_FFE4, 5'd9, 32'h0000_000F, 0, 0, 0);
    step("sllv_sh",    1'b0, 4'd7,  32'h0000_0001, 32'h0000_0021, 5'd0, 32'h0000_0002, 0, 0, 0);
    step("undef_12",   1'b0, 4'd12, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 32'h0, 0, 1, 0);
    step("undef_15",   1'b0, 4'd15, 32'h0000_0001, 32'h0000_0001, 5'd1, 32'h0, 0, 1, 0);

    // Back-to-back stream, one new op per cycle, with a reset mid-stream.
    step("b2b_add",    1'b0, 4'd0,  32'd7, 32'd8, 5'd0, 32'd15, 0, 0, 0);
    step("b2b_sub0",   1'b0, 4'd1,  32'd5, 32'd5, 5'd0, 32'h0, 0, 1, 1);
    step("b2b_and",    1'b0, 4'd2,  32'hFF00_FF00, 32'h0FF0_0FF0, 5'd0, 32'h0F00_0F00, 0, 0, 0);
    step("b2b_xor",    1'b0, 4'd3,  32'hAAAA_AAAA, 32'h5555_5555, 5'd0, 32'hFFFF_FFFF, 1, 0, 0);
    step("b2b_rst",    1'b1, 4'd0,  32'hFFFF_FFFF, 32'd1, 5'd0, 32'h0, 0, 1, 0);
    step("b2b_sllv",   1'b0, 4'd7,  32'h0000_0001, 32'h0000_001F, 5'd0, 32'h8000_0000, 1, 0, 0);
    step("b2b_srav",   1'b0, 4'd9,  32'h8000_0000, 32'h0000_003F, 5'd0, 32'hFFFF_FFFF, 1, 0, 0);
    step("b2b_srl",    1'b0, 4'd5,  32'h0000_0003, 32'd0, 5'd1, 32'h0000_0001, 0, 0, 1);
    step("b2b_comp0",  1'b0, 4'd10, 32'd0, 32'd0, 5'd0, 32'h0, 0, 1, 0);
    step("b2b_add2",   1'b0, 4'd0,  32'd1, 32'd2, 5'd0, 32'd3, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
